// File: rtl/mprj_wb_pkg.sv
// Shared types and constants for the user-project Wishbone arbiter.
//   arb_state_t : arbiter FSM states
//   WB_ERR_DATA : read data returned alongside an error termination
//   wb_req_t    : master-side request bundle used by the grant mux
package mprj_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

    localparam logic [31:0] WB_ERR_DATA = 32'h0;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Per-transfer acknowledge timeout.
//   clk, rst : clock, synchronous active-high reset
//   active   : arbiter is in a granted bus cycle
//   stb      : strobe currently presented to the slave
//   ack      : slave acknowledge
//   clr      : clears the sticky flag
//   expire   : combinational, high in the cycle the limit is hit without ack
//   flag     : sticky timeout indicator
module wb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stb,
    input  logic ack,
    input  logic clr,
    output logic expire,
    output logic flag
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire = active && stb && !ack && (cnt_q == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || !active || !stb || ack) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // A new timeout takes precedence over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag <= 1'b0;
        end else if (expire) begin
            flag <= 1'b1;
        end else if (clr) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/mprj_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the user project slave.
//   wb_clk_i, wb_rst_i : bus clock, synchronous active-high reset
//   m0_* / m1_*        : master ports (m0 = management core, m1 = secondary)
//   s_*                : shared slave port
//   gnt_o              : one-hot current grant (bit 0 = m0)
//   timeout_o          : sticky ack-timeout flag, cleared by timeout_clr_i
module mprj_wb_arbiter
    import mprj_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  gnt_o,
    output logic        timeout_o,
    input  logic        timeout_clr_i
);

    arb_state_t state_q, state_nxt;
    logic [1:0] gnt_q, gnt_nxt;
    logic       last_m1_q, last_m1_nxt;   // 1: m1 was served last, m0 has priority

    wb_req_t    m0_req, m1_req, sel_req;
    logic       busy, expire, ack_fwd, gnt_cyc;

    assign busy = (state_q == BUSY);

    always_comb begin
        m0_req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                   sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
        m1_req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                   sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};
        sel_req = '0;
        if (busy) begin
            if (gnt_q[1]) begin
                sel_req = m1_req;
            end else if (gnt_q[0]) begin
                sel_req = m0_req;
            end
        end
    end

    assign gnt_cyc = sel_req.cyc;

    assign s_cyc_o = sel_req.cyc;
    assign s_stb_o = sel_req.cyc && sel_req.stb;
    assign s_we_o  = sel_req.we;
    assign s_sel_o = sel_req.sel;
    assign s_adr_o = sel_req.adr;
    assign s_dat_o = sel_req.dat;

    // Acks outside an active granted cycle (IDLE, FLUSH, cyc dropped) are discarded.
    assign ack_fwd = busy && gnt_cyc && s_ack_i;

    always_comb begin
        m0_ack_o = ack_fwd && gnt_q[0];
        m1_ack_o = ack_fwd && gnt_q[1];
        m0_err_o = expire && gnt_q[0];
        m1_err_o = expire && gnt_q[1];
        m0_dat_o = '0;
        m1_dat_o = '0;
        if (busy && gnt_q[0]) begin
            m0_dat_o = expire ? WB_ERR_DATA : s_dat_i;
        end
        if (busy && gnt_q[1]) begin
            m1_dat_o = expire ? WB_ERR_DATA : s_dat_i;
        end
    end

    wb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .active (busy),
        .stb    (s_stb_o),
        .ack    (s_ack_i),
        .clr    (timeout_clr_i),
        .expire (expire),
        .flag   (timeout_o)
    );

    always_comb begin
        state_nxt   = state_q;
        gnt_nxt     = gnt_q;
        last_m1_nxt = last_m1_q;
        unique case (state_q)
            IDLE: begin
                if ((m0_cyc_i && m0_stb_i) || (m1_cyc_i && m1_stb_i)) begin
                    state_nxt = BUSY;
                    if (m0_cyc_i && m0_stb_i && (!(m1_cyc_i && m1_stb_i) || last_m1_q)) begin
                        gnt_nxt = 2'b01;
                    end else begin
                        gnt_nxt = 2'b10;
                    end
                end
            end
            BUSY: begin
                if (!gnt_cyc) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    last_m1_nxt = gnt_q[1];
                end else if (expire) begin
                    state_nxt   = FLUSH;
                    gnt_nxt     = '0;
                    last_m1_nxt = gnt_q[1];
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            gnt_q     <= gnt_nxt;
            last_m1_q <= last_m1_nxt;
        end
    end

    assign gnt_o = gnt_q;

endmodule

// File: tb/tb_mprj_wb_arbiter.sv
// Directed self-checking bench for mprj_wb_arbiter (TIMEOUT_CYC = 8).
module tb_mprj_wb_arbiter;

    logic        wb_clk_i, wb_rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic [1:0]  gnt_o;
    logic        timeout_o, timeout_clr_i;

    int checks = 0;
    int fails  = 0;

    logic [31:0] burst_dat [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    mprj_wb_arbiter #(
        .TIMEOUT_CYC (8),
        .CNT_W       (16)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .m0_cyc_i      (m0_cyc_i),
        .m0_stb_i      (m0_stb_i),
        .m0_we_i       (m0_we_i),
        .m0_sel_i      (m0_sel_i),
        .m0_adr_i      (m0_adr_i),
        .m0_dat_i      (m0_dat_i),
        .m0_ack_o      (m0_ack_o),
        .m0_err_o      (m0_err_o),
        .m0_dat_o      (m0_dat_o),
        .m1_cyc_i      (m1_cyc_i),
        .m1_stb_i      (m1_stb_i),
        .m1_we_i       (m1_we_i),
        .m1_sel_i      (m1_sel_i),
        .m1_adr_i      (m1_adr_i),
        .m1_dat_i      (m1_dat_i),
        .m1_ack_o      (m1_ack_o),
        .m1_err_o      (m1_err_o),
        .m1_dat_o      (m1_dat_o),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_we_o        (s_we_o),
        .s_sel_o       (s_sel_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_ack_i       (s_ack_i),
        .s_dat_i       (s_dat_i),
        .gnt_o         (gnt_o),
        .timeout_o     (timeout_o),
        .timeout_clr_i (timeout_clr_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
        s_ack_i = 0; s_dat_i = '0; timeout_clr_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        wb_rst_i = 1;
        step();
        step();
        s_ack_i = 1; s_dat_i = 32'hFFFF_FFFF;
        #1;
        checks++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin fails++; $display("FAIL reset_s_cyc_stb: got %b%b want 00", s_cyc_o, s_stb_o); end
        checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b%b want 00", m0_ack_o, m1_ack_o); end
        checks++; if (m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0) begin fails++; $display("FAIL reset_dat: got %h %h want 0 0", m0_dat_o, m1_dat_o); end
        checks++; if (timeout_o !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
        clear_inputs();
        wb_rst_i = 0;
        step();
    endtask

    task automatic test_single();
        int n0 = 0;
        int n1 = 0;
        logic gnt_ok = 1'b1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h3000_0000; m0_dat_i = 32'hA5A5_0001;
        #1;
        checks++; if (s_cyc_o !== 1'b0) begin fails++; $display("FAIL single_latency: got s_cyc %b want 0", s_cyc_o); end
        step();
        checks++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b1) begin fails++; $display("FAIL single_s_ctl: got %b%b%b want 111", s_cyc_o, s_stb_o, s_we_o); end
        checks++; if (s_adr_o !== 32'h3000_0000 || s_dat_o !== 32'hA5A5_0001 || s_sel_o !== 4'hF) begin fails++; $display("FAIL single_s_bus: got %h %h %h want 30000000 a5a50001 f", s_adr_o, s_dat_o, s_sel_o); end
        for (int i = 0; i < 4; i++) begin
            s_ack_i = (i == 3);
            #1;
            if (m0_ack_o === 1'b1) n0++;
            if (m1_ack_o === 1'b1) n1++;
            if (gnt_o !== 2'b01) gnt_ok = 1'b0;
            step();
        end
        clear_inputs();
        #1;
        if (m0_ack_o === 1'b1) n0++;
        checks++; if (n0 != 1) begin fails++; $display("FAIL single_m0_ack_count: got %0d want 1", n0); end
        checks++; if (n1 != 0) begin fails++; $display("FAIL single_m1_ack_count: got %0d want 0", n1); end
        checks++; if (gnt_ok !== 1'b1) begin fails++; $display("FAIL single_gnt_hold: got %b want 1", gnt_ok); end
        step();
        checks++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL single_release: got %b want 00", gnt_o); end
    endtask

    task automatic test_contention();
        wb_rst_i = 1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_00A0;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_00B0;
        step();
        step();
        wb_rst_i = 0;
        step();
        checks++; if (gnt_o !== 2'b01 || s_adr_o !== 32'hA0) begin fails++; $display("FAIL cont_first_m0: got gnt %b adr %h want 01 a0", gnt_o, s_adr_o); end
        s_ack_i = 1;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin fails++; $display("FAIL cont_ack_m0: got %b%b want 10", m0_ack_o, m1_ack_o); end
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        checks++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL cont_bubble: got %b want 00", gnt_o); end
        step();
        checks++; if (gnt_o !== 2'b10 || s_adr_o !== 32'hB0) begin fails++; $display("FAIL cont_second_m1: got gnt %b adr %h want 10 b0", gnt_o, s_adr_o); end
        s_ack_i = 1;
        #1;
        checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin fails++; $display("FAIL cont_ack_m1: got m1 %b m0 %b want 1 0", m1_ack_o, m0_ack_o); end
        step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        checks++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL cont_alternate: got %b want 01", gnt_o); end
        s_ack_i = 1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_lock();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_adr_i = 32'h3000_0100;
        step();
        checks++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL lock_grant_m1: got %b want 10", gnt_o); end
        for (int k = 0; k < 4; k++) begin
            s_ack_i = 1; s_dat_i = burst_dat[k];
            if (k == 1) begin
                m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0200;
            end
            #1;
            checks++; if (m1_ack_o !== 1'b1 || m1_dat_o !== burst_dat[k]) begin fails++; $display("FAIL lock_beat%0d: got ack %b dat %h want 1 %h", k, m1_ack_o, m1_dat_o, burst_dat[k]); end
            checks++; if (gnt_o !== 2'b10 || m0_ack_o !== 1'b0 || m0_dat_o !== 32'h0) begin fails++; $display("FAIL lock_hold%0d: got gnt %b m0ack %b m0dat %h want 10 0 0", k, gnt_o, m0_ack_o, m0_dat_o); end
            step();
        end
        s_ack_i = 0; s_dat_i = '0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        checks++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL lock_bubble: got %b want 00", gnt_o); end
        step();
        checks++; if (gnt_o !== 2'b01 || s_adr_o !== 32'h3000_0200) begin fails++; $display("FAIL lock_m0_after: got gnt %b adr %h want 01 30000200", gnt_o, s_adr_o); end
        s_ack_i = 1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0300;
        s_dat_i = 32'hDEAD_BEEF;
        step();
        for (int i = 1; i <= 8; i++) begin
            #1;
            if (i < 8) begin
                checks++; if (m0_err_o !== 1'b0) begin fails++; $display("FAIL to_early_err%0d: got %b want 0", i, m0_err_o); end
            end else begin
                checks++; if (m0_err_o !== 1'b1 || m0_ack_o !== 1'b0 || m0_dat_o !== 32'h0) begin fails++; $display("FAIL to_err: got err %b ack %b dat %h want 1 0 0", m0_err_o, m0_ack_o, m0_dat_o); end
                checks++; if (timeout_o !== 1'b0) begin fails++; $display("FAIL to_flag_early: got %b want 0", timeout_o); end
            end
            step();
        end
        clear_inputs();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h3000_0400;
        s_ack_i = 1;
        #1;
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || gnt_o !== 2'b00) begin fails++; $display("FAIL to_flush: got cyc %b stb %b gnt %b want 0 0 00", s_cyc_o, s_stb_o, gnt_o); end
        checks++; if (timeout_o !== 1'b1) begin fails++; $display("FAIL to_flag_set: got %b want 1", timeout_o); end
        checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin fails++; $display("FAIL to_flush_late_ack: got %b%b%b want 000", m0_ack_o, m1_ack_o, m0_err_o); end
        step();
        s_ack_i = 0;
        #1;
        checks++; if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin fails++; $display("FAIL to_idle_after_flush: got gnt %b cyc %b want 00 0", gnt_o, s_cyc_o); end
        step();
        checks++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL to_m1_grant: got %b want 10", gnt_o); end
        s_ack_i = 1;
        #1;
        checks++; if (m1_ack_o !== 1'b1 || m1_err_o !== 1'b0) begin fails++; $display("FAIL to_m1_xfer: got ack %b err %b want 1 0", m1_ack_o, m1_err_o); end
        step();
        clear_inputs();
        #1;
        checks++; if (timeout_o !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", timeout_o); end
        step();
        timeout_clr_i = 1;
        step();
        timeout_clr_i = 0;
        checks++; if (timeout_o !== 1'b0) begin fails++; $display("FAIL to_clear: got %b want 0", timeout_o); end
    endtask

    task automatic test_race();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0500;
        step();
        for (int i = 0; i < 7; i++) step();
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0) begin fails++; $display("FAIL race_ack_wins: got ack %b err %b want 1 0", m0_ack_o, m0_err_o); end
        checks++; if (m0_dat_o !== 32'h1234_5678) begin fails++; $display("FAIL race_dat: got %h want 12345678", m0_dat_o); end
        step();
        clear_inputs();
        #1;
        checks++; if (timeout_o !== 1'b0) begin fails++; $display("FAIL race_flag: got %b want 0", timeout_o); end
        step();
        checks++; if (gnt_o !== 2'b00 || timeout_o !== 1'b0) begin fails++; $display("FAIL race_idle: got gnt %b flag %b want 00 0", gnt_o, timeout_o); end
    endtask

    task automatic test_reset_mid();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h3000_0600;
        step();
        checks++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL rmid_grant: got %b want 10", gnt_o); end
        step();
        wb_rst_i = 1;
        step();
        s_dat_i = 32'hCAFE_F00D;
        #1;
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || gnt_o !== 2'b00) begin fails++; $display("FAIL rmid_drop: got cyc %b stb %b gnt %b want 0 0 00", s_cyc_o, s_stb_o, gnt_o); end
        checks++; if (m1_dat_o !== 32'h0 || m1_ack_o !== 1'b0 || timeout_o !== 1'b0) begin fails++; $display("FAIL rmid_outs: got dat %h ack %b flag %b want 0 0 0", m1_dat_o, m1_ack_o, timeout_o); end
        wb_rst_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        s_ack_i = 1;
        #1;
        checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || s_cyc_o !== 1'b0) begin fails++; $display("FAIL rmid_late_ack: got %b%b cyc %b want 00 0", m0_ack_o, m1_ack_o, s_cyc_o); end
        step();
        s_ack_i = 0; s_dat_i = '0;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        checks++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL rmid_m0_priority: got %b want 01", gnt_o); end
        s_ack_i = 1;
        step();
        clear_inputs();
        step();
    endtask

    initial begin
        wb_rst_i = 1;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mprj_wb_arbiter.md
Name: mprj_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares the exported user-project Wishbone slave port.
- Master 0 is the management core (mprj_cyc_o/stb_o/...). Master 1 is a secondary bus master, e.g. the FSIC host bridge.
- Round-robin grant, locked for the whole bus cycle (cyc held).
- Per-transfer ack timeout: a hung user slave returns an error instead of stalling the CPU forever.
- Sits between the core wrapper's mprj_* bus and the user project wrapper.

Parameters:
- TIMEOUT_CYC, 255, cycles without s_ack_i (while stb pending) before an error termination; legal range 1..65535.
- CNT_W, 16, width of the timeout counter.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  reset; synchronous, active-high
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 bus-cycle, strobe and write-enable
- m0_sel_i  in  4  master 0 byte selects
- m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge and error
- m0_dat_o  out  32  master 0 read data
- m1_*  same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave bus-cycle, strobe and write-enable
- s_sel_o  out  4  slave byte selects
- s_adr_o, s_dat_o  out  32 each  slave address and write data
- s_ack_i  in  1  slave acknowledge
- s_dat_i  in  32  slave read data
- gnt_o  out  2  one-hot current grant
- timeout_o  out  1  sticky timeout flag
- timeout_clr_i  in  1  clears timeout_o

Behaviour:
- Synchronous active-high reset, applied on the next rising edge of wb_clk_i. Effects:
  - State goes to IDLE; gnt_o=0.
  - Round-robin pointer set so that m0 has priority.
  - Timeout counter cleared; timeout_o=0.
  - All s_* outputs and all m*_ack_o/err_o driven 0. m*_dat_o=0.
  - Reset during an active transfer drops s_cyc_o at that edge. Any slave ack arriving afterwards is ignored.
- State machine, states IDLE, BUSY, FLUSH:
  - IDLE: a request is mX_cyc_i & mX_stb_i. With a single request, grant it. With both requesting, grant the master that did not hold the last grant. Register gnt_o and go to BUSY. Latency: request at edge N gives s_cyc_o/s_stb_o high after edge N+1.
  - BUSY: the granted master's cyc/stb/we/sel/adr/dat are muxed combinationally onto s_*, gated by gnt_o.
    - s_ack_i is routed combinationally to the granted master's ack_o; s_dat_i goes to its dat_o.
    - The non-granted master sees ack=err=0 and dat_o=0.
    - The grant holds while the granted master's cyc_i=1, covering multi-beat block and RMW cycles. The other master waits.
    - Granted cyc_i falling to 0 leads to IDLE next cycle; the pointer records this master as last served.
  - FLUSH: entered on timeout. s_cyc_o=s_stb_o=0 for exactly 1 cycle, then IDLE.
- Timeout:
  - The counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=0. It clears on s_ack_i, on leaving BUSY, and while stb=0.
  - When the counter equals TIMEOUT_CYC-1 with no ack, the granted master gets mX_err_o=1 for exactly that cycle; ack stays 0 and dat_o=0.
  - In the same cycle timeout_o is set (sticky) and the state goes to FLUSH.
  - The granted master is expected to drop cyc after err. If it still holds cyc after FLUSH, it is re-arbitrated as a fresh request.
- Simultaneous events:
  - s_ack_i in the timeout cycle: ack wins, no err, counter cleared.
  - timeout_clr_i together with a new timeout: set wins.
  - Both masters requesting at reset release: m0 wins.
- Late ack: s_ack_i while IDLE or FLUSH is dropped and never forwarded.
- Arbiter overhead: no bubble inside a locked cycle. One idle cycle between different grants (BUSY -> IDLE -> BUSY).

Decomposition:
- Shared package mprj_wb_pkg holds:
  - the state enum {IDLE, BUSY, FLUSH};
  - constant WB_ERR_DATA=32'h0 (data returned on error);
  - a struct bundling cyc/stb/we/sel/adr/dat for the master-side mux.
- One natural sub-module: wb_timeout_cnt (counter, compare, sticky flag), reusable for the housekeeping bus.

Test Plan:
- Single master: m0 write, adr 0x3000_0000, dat 0xA5A5_0001. Slave acks 3 cycles after s_stb_o rises -> s_cyc_o high one cycle after request; m0_ack_o pulses once; gnt_o=01 throughout; m1 sees no ack.
- Contention: m0 and m1 both request at reset release -> m0 served first. m1 then granted after exactly one IDLE cycle. Next simultaneous request grants m0 again (alternation).
- Lock: m1 holds cyc for a 4-beat read, slave returns 0x11, 0x22, 0x33, 0x44. m0 requests mid-burst -> m0 is not granted until m1 drops cyc; m1 receives all 4 data words in order.
- Timeout: TIMEOUT_CYC=8, slave never acks -> m0_err_o high on the 8th stb cycle; timeout_o=1; one FLUSH cycle; s_cyc_o=0. A following m1 transfer completes normally. timeout_clr_i clears the flag.
- Race: s_ack_i arrives in the same cycle the counter hits limit -> m0_ack_o=1, m0_err_o=0, timeout_o stays 0.
- Reset mid-transfer: wb_rst_i asserted during m1 BUSY; slave acks 2 cycles later -> all outputs 0 after the edge; late ack not forwarded; next request goes to m0.
